// File: rtl/mux_valve_sequencer.sv
// mux_valve_sequencer: break-before-make sequencer for a binary-tree valve
// multiplexer. A request is latched, every valve is closed for SETTLE_CYCLES,
// then the complementary per-level pattern for the leaf is applied for
// SETTLE_CYCLES before the route is reported as held.
// Optional build macro: MUX_HOLD_TIMEOUT_EN (auto-isolate after HOLD_MAX
// cycles in ROUTED with no new request, pulsing timeout).
module mux_valve_sequencer #(
    parameter int unsigned LEVELS        = 6,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned HOLD_MAX      = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEVELS-1:0] req_addr,
    input  logic              req_iso,
    output logic [LEVELS-1:0] ctl_0,
    output logic [LEVELS-1:0] ctl_1,
    output logic              route_valid,
    output logic [LEVELS-1:0] route_addr,
    output logic              timeout
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("HOLD_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLOSE  = 2'd1,
        OPEN   = 2'd2,
        ROUTED = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              pend;
    logic [LEVELS-1:0] addr_q;
    logic              iso_q;

`ifdef MUX_HOLD_TIMEOUT_EN
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold;
`endif

    // Level j (c_(j+1)_x) is steered by address bit LEVELS-1-j: the root
    // level uses the MSB.
    function automatic logic [LEVELS-1:0] path_bits(input logic [LEVELS-1:0] a);
        logic [LEVELS-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < LEVELS; j++) begin
            r[j] = a[LEVELS-1-j];
        end
        return r;
    endfunction

    // Sequencer FSM with all outputs registered. The accepted request spends
    // one capture cycle (pend) before CLOSE so the close phase is exactly
    // SETTLE_CYCLES long as seen on ctl_0/ctl_1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pend        <= 1'b0;
            addr_q      <= '0;
            iso_q       <= 1'b0;
            ctl_0       <= '1;
            ctl_1       <= '1;
            route_valid <= 1'b0;
            route_addr  <= '0;
            req_ready   <= 1'b1;
            timeout     <= 1'b0;
`ifdef MUX_HOLD_TIMEOUT_EN
            hold        <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            if (req_valid && req_ready) begin
                addr_q      <= req_addr;
                iso_q       <= req_iso;
                pend        <= 1'b1;
                req_ready   <= 1'b0;
                route_valid <= 1'b0;
            end else if (pend) begin
                pend  <= 1'b0;
                state <= CLOSE;
                cnt   <= LOAD;
                ctl_0 <= '1;
                ctl_1 <= '1;
            end else begin
                case (state)
                    CLOSE: begin
                        if (cnt == '0) begin
                            if (iso_q) begin
                                state     <= IDLE;
                                req_ready <= 1'b1;
                            end else begin
                                state <= OPEN;
                                cnt   <= LOAD;
                                ctl_0 <= path_bits(addr_q);
                                ctl_1 <= ~path_bits(addr_q);
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    OPEN: begin
                        if (cnt == '0) begin
                            state       <= ROUTED;
                            route_valid <= 1'b1;
                            route_addr  <= addr_q;
                            req_ready   <= 1'b1;
`ifdef MUX_HOLD_TIMEOUT_EN
                            hold        <= '0;
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ROUTED: begin
`ifdef MUX_HOLD_TIMEOUT_EN
                        if (hold == HW'(HOLD_MAX - 1)) begin
                            state       <= CLOSE;
                            cnt         <= LOAD;
                            iso_q       <= 1'b1;
                            ctl_0       <= '1;
                            ctl_1       <= '1;
                            route_valid <= 1'b0;
                            req_ready   <= 1'b0;
                            timeout     <= 1'b1;
                        end else begin
                            hold <= hold + 1'b1;
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_valve_sequencer.sv
// Directed, table-driven bench for mux_valve_sequencer with SETTLE_CYCLES=4.
module tb_mux_valve_sequencer;

    localparam int unsigned L = 6;
    localparam int unsigned S = 4;
`ifdef MUX_HOLD_TIMEOUT_EN
    localparam int unsigned HM = 10;
`else
    localparam int unsigned HM = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [L-1:0] req_addr = '0;
    logic         req_iso = 1'b0;
    logic [L-1:0] ctl_0;
    logic [L-1:0] ctl_1;
    logic         route_valid;
    logic [L-1:0] route_addr;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    mux_valve_sequencer #(
        .LEVELS(L),
        .SETTLE_CYCLES(S),
        .HOLD_MAX(HM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_iso(req_iso),
        .ctl_0(ctl_0),
        .ctl_1(ctl_1),
        .route_valid(route_valid),
        .route_addr(route_addr),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0] addr;
        logic         iso;
        logic [L-1:0] e0;
        logic [L-1:0] e1;
    } vec_t;

    vec_t tbl[8];
    logic [L-1:0] last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // No valve pair may ever have both sides open.
    always @(negedge clk) begin
        if (rst_n) chk("pair_invariant", {26'd0, ~(ctl_0 | ctl_1)}, 32'd0);
    end

    // Waits (bounded) for req_ready, presents a request, and returns on the
    // negedge just after the accepting edge.
    task automatic accept(input logic [L-1:0] a, input logic iso);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_iso   = iso;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_iso   = 1'b0;
        @(negedge clk);
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{6'd37, 1'b0, 6'b101001, 6'b010110};
        tbl[1] = '{6'd37, 1'b0, 6'b101001, 6'b010110};
        tbl[2] = '{6'd0,  1'b0, 6'b000000, 6'b111111};
        tbl[3] = '{6'd63, 1'b0, 6'b111111, 6'b000000};
        tbl[4] = '{6'd1,  1'b0, 6'b100000, 6'b011111};
        tbl[5] = '{6'd48, 1'b0, 6'b000011, 6'b111100};
        tbl[6] = '{6'd21, 1'b1, 6'b111111, 6'b111111};
        tbl[7] = '{6'd5,  1'b0, 6'b101000, 6'b010111};
        last_addr = '0;

        // Reset state
        skip(2);
        chk("rst_ctl_0", {26'd0, ctl_0}, 32'h3f);
        chk("rst_ctl_1", {26'd0, ctl_1}, 32'h3f);
        chk("rst_route_valid", {31'd0, route_valid}, 32'd0);
        chk("rst_route_addr", {26'd0, route_addr}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        // Table-driven routes, back-to-back and isolate
        for (int v = 0; v < 8; v++) begin
            accept(tbl[v].addr, tbl[v].iso);
            chk("acc_route_valid", {31'd0, route_valid}, 32'd0);
            chk("acc_ready", {31'd0, req_ready}, 32'd0);
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if (k == 1 || k == 4) begin
                    chk("close_ctl_0", {26'd0, ctl_0}, 32'h3f);
                    chk("close_ctl_1", {26'd0, ctl_1}, 32'h3f);
                end
                if (k >= 1 && k <= 4) chk("close_ready", {31'd0, req_ready}, 32'd0);
                if (k == 5) begin
                    chk("p5_ctl_0", {26'd0, ctl_0}, {26'd0, tbl[v].e0});
                    chk("p5_ctl_1", {26'd0, ctl_1}, {26'd0, tbl[v].e1});
                    chk("p5_ready", {31'd0, req_ready}, {31'd0, tbl[v].iso});
                    chk("p5_route_valid", {31'd0, route_valid}, 32'd0);
                end
                if (tbl[v].iso && k == 5) begin
                    chk("iso_route_addr_kept", {26'd0, route_addr}, {26'd0, last_addr});
                    break;
                end
                if (k == 8) chk("open_route_valid", {31'd0, route_valid}, 32'd0);
                if (k == 9) begin
                    chk("routed_valid", {31'd0, route_valid}, 32'd1);
                    chk("routed_addr", {26'd0, route_addr}, {26'd0, tbl[v].addr});
                    chk("routed_ready", {31'd0, req_ready}, 32'd1);
                    chk("routed_ctl_0", {26'd0, ctl_0}, {26'd0, tbl[v].e0});
                    last_addr = tbl[v].addr;
                end
            end
        end

        // Busy: request held during CLOSE/OPEN of a previous one
        accept(6'd37, 1'b0);
        req_valid = 1'b1;
        req_addr  = 6'd0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k < 9) chk("busy_ready_low", {31'd0, req_ready}, 32'd0);
        end
        chk("busy_routed_valid", {31'd0, route_valid}, 32'd1);
        chk("busy_routed_addr", {26'd0, route_addr}, 32'd37);
        chk("busy_ready_high", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy_accepted", {31'd0, route_valid}, 32'd0);
        skip(9);
        chk("busy_final_valid", {31'd0, route_valid}, 32'd1);
        chk("busy_final_addr", {26'd0, route_addr}, 32'd0);
        chk("busy_final_ctl_0", {26'd0, ctl_0}, 32'h00);
        chk("busy_final_ctl_1", {26'd0, ctl_1}, 32'h3f);

        // Reset in the middle of OPEN
        accept(6'd37, 1'b0);
        skip(6);
        chk("mid_open_ctl_0", {26'd0, ctl_0}, 32'h29);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctl_0", {26'd0, ctl_0}, 32'h3f);
        chk("async_rst_ctl_1", {26'd0, ctl_1}, 32'h3f);
        chk("async_rst_valid", {31'd0, route_valid}, 32'd0);
        chk("async_rst_addr", {26'd0, route_addr}, 32'd0);
        skip(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        skip(3);
        chk("post_rst_idle_ctl", {26'd0, ctl_0 & ctl_1}, 32'h3f);

        // Hold behaviour in ROUTED
        accept(6'd5, 1'b0);
        skip(9);
        chk("hold_routed", {31'd0, route_valid}, 32'd1);
`ifdef MUX_HOLD_TIMEOUT_EN
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k < 10) chk("to_quiet", {31'd0, timeout}, 32'd0);
            if (k == 10) begin
                chk("to_pulse", {31'd0, timeout}, 32'd1);
                chk("to_ctl_0", {26'd0, ctl_0}, 32'h3f);
                chk("to_ctl_1", {26'd0, ctl_1}, 32'h3f);
                chk("to_valid", {31'd0, route_valid}, 32'd0);
            end
            if (k == 11) chk("to_single", {31'd0, timeout}, 32'd0);
            if (k == 13) chk("to_closing_ready", {31'd0, req_ready}, 32'd0);
            if (k == 14) chk("to_idle_ready", {31'd0, req_ready}, 32'd1);
        end
`else
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (timeout !== 1'b0 || route_valid !== 1'b1 || ctl_0 !== 6'b101000) bad++;
            end
            chk("hold_1000_cycles", bad, 32'd0);
            chk("hold_timeout_low", {31'd0, timeout}, 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
